// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, start bit, 8 data bits LSB first, odd parity, stop, device ACK.
// Define PS2_HOST_TX_TIMEOUT_EN to add a frame watchdog that aborts a stalled frame with tx_error.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 4000,
  parameter int unsigned TIMEOUT_CYCLES = 600000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  // Handshake: a byte is taken on any cycle with tx_valid=1 and tx_ready=1; tx_valid while
  // tx_ready=0 has no effect, and tx_ready stays low until the frame ends (done, error or reset).

  typedef enum logic [2:0] {IDLE, INHIBIT, SEND, ACK, RELEASE} state_t;

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST  = IW'(INHIBIT_CYCLES - 1);
  localparam logic [IW-1:0] INH_START = IW'(INHIBIT_CYCLES - 2);

  state_t        state;
  logic [7:0]    shift_data;
  logic          parity;
  logic [3:0]    bit_cnt;
  logic [IW-1:0] inh_cnt;
  logic          nack;

  logic clk_s1, clk_s2, clk_prev;
  logic data_s1, data_s2;
  logic clk_fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk_in;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data_in;
      data_s2  <= data_s1;
    end
  end

  assign clk_fall = clk_prev & ~clk_s2;

`ifdef PS2_HOST_TX_TIMEOUT_EN
  localparam logic [19:0] WD_LAST = 20'(TIMEOUT_CYCLES - 1);
  logic [19:0] wd;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tx_ready    <= 1'b1;
      busy        <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
      shift_data  <= '0;
      parity      <= 1'b0;
      bit_cnt     <= '0;
      inh_cnt     <= '0;
      nack        <= 1'b0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
      wd          <= '0;
`endif
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid) begin
            shift_data <= tx_data;
            parity     <= ~^tx_data;
            inh_cnt    <= '0;
            tx_ready   <= 1'b0;
            busy       <= 1'b1;
            ps2_clk_oe <= 1'b1;
            if (INHIBIT_CYCLES < 2) ps2_data_oe <= 1'b1;
            state      <= INHIBIT;
          end
        end
        INHIBIT: begin
          inh_cnt <= inh_cnt + 1'b1;
          // Start bit goes low one cycle before the clock is released.
          if (inh_cnt == INH_START) ps2_data_oe <= 1'b1;
          if (inh_cnt == INH_LAST) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b1;
            bit_cnt     <= '0;
            inh_cnt     <= '0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
            wd          <= '0;
`endif
            state       <= SEND;
          end
        end
        SEND: begin
          if (clk_fall) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt < 4'd8) begin
              ps2_data_oe <= ~shift_data[bit_cnt[2:0]];
            end else if (bit_cnt == 4'd8) begin
              ps2_data_oe <= ~parity;
            end else begin
              ps2_data_oe <= 1'b0;
              state       <= ACK;
            end
          end
        end
        ACK: begin
          if (clk_fall) begin
            nack  <= data_s2;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          if (clk_s2 && data_s2) begin
            tx_done  <= ~nack;
            tx_error <= nack;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          tx_ready    <= 1'b1;
          busy        <= 1'b0;
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
        end
      endcase

`ifdef PS2_HOST_TX_TIMEOUT_EN
      // Watchdog overrides whatever the frame logic decided this cycle.
      if (state == SEND || state == ACK || state == RELEASE) begin
        if (wd == WD_LAST) begin
          state       <= IDLE;
          tx_ready    <= 1'b1;
          busy        <= 1'b0;
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          tx_done     <= 1'b0;
          tx_error    <= 1'b1;
        end else begin
          wd <= wd + 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-collector bus with a behavioural PS/2 device, frame model from the protocol rules.
module tb_ps2_host_tx;

  localparam int INH = 64;
  localparam int TMO = 1000;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       tx_done;
  logic       tx_error;

  logic dev_clk;
  logic dev_data;

  int n_checks = 0;
  int n_fail   = 0;

  bit mon_en       = 1'b0;
  bit frame_active = 1'b0;
  bit ended        = 1'b0;
  int done_pulses  = 0;
  int err_pulses   = 0;
  int busy_drops   = 0;
  int mon_viol     = 0;

  // Wired-AND bus: either side can pull a line low.
  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL global_watchdog: got no end of test, required end within time limit");
    $fatal(1, "simulation time limit");
  end

  // ---------------- bus monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      if (tx_done) done_pulses++;
      if (tx_error) err_pulses++;
      if (tx_done && tx_error) mon_viol++;
      if (ps2_clk_oe && !busy) mon_viol++;
      if (tx_ready == busy) mon_viol++;
      if (!frame_active) ended = 1'b0;
      else if (tx_done || tx_error) ended = 1'b1;
      else if (!busy && !ended) busy_drops++;
    end
  end

  // ---------------- reference model ----------------
  // Frame bits in wire order after the start bit: data LSB first, odd parity, stop(1).
  function automatic logic [9:0] frame_bits(input logic [7:0] d);
    int ones;
    logic par;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    par = ((ones % 2) == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, d};
  endfunction

  // ---------------- driver: one full frame with a behavioural device ----------------
  task automatic run_frame(input logic [7:0] d, input bit ack, input bit inject, input int half,
                           output int inh_len, output int data_at, output logic start_bit,
                           output logic [9:0] bits, output int done_n, output int err_n,
                           output int drops, output bit ended_ok);
    int base_done, base_err, base_drops, t;
    base_done  = done_pulses;
    base_err   = err_pulses;
    base_drops = busy_drops;
    inh_len    = 0;
    data_at    = -1;
    bits       = '0;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = inject;
    if (inject) tx_data = 8'h55;
    frame_active = 1'b1;
    while (ps2_clk_oe && inh_len < INH + 100) begin
      if (ps2_data_oe && data_at < 0) data_at = inh_len;
      inh_len++;
      @(negedge clk);
    end
    start_bit = ps2_data_in;
    repeat (10) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      repeat (half) @(negedge clk);
      dev_clk = 1'b0;
      repeat (half) @(negedge clk);
      dev_clk = 1'b1;
      bits[k] = ps2_data_in;
    end
    tx_valid = 1'b0;
    repeat (half) @(negedge clk);
    dev_data = ~ack;
    repeat (half) @(negedge clk);
    dev_clk = 1'b0;
    repeat (half) @(negedge clk);
    dev_clk = 1'b1;
    repeat (half) @(negedge clk);
    dev_data = 1'b1;
    t = 0;
    while ((done_pulses + err_pulses) == (base_done + base_err) && t < 500) begin
      @(negedge clk);
      t++;
    end
    ended_ok = (t < 500);
    repeat (5) @(negedge clk);
    frame_active = 1'b0;
    done_n = done_pulses - base_done;
    err_n  = err_pulses - base_err;
    drops  = busy_drops - base_drops;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready: got %b required 1", tx_ready); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_checks++;
    if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
      n_fail++; $display("FAIL reset_oe: got %b required 00", {ps2_clk_oe, ps2_data_oe});
    end
    n_checks++;
    if ({tx_done, tx_error} !== 2'b00) begin
      n_fail++; $display("FAIL reset_pulses: got %b required 00", {tx_done, tx_error});
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
  endtask

  task automatic test_ack_ed;
    int inh_len, data_at, done_n, err_n, drops;
    logic start_bit;
    logic [9:0] bits;
    bit ended_ok;
    logic [9:0] exp;
    exp = 10'b11_1110_1101;
    run_frame(8'hED, 1'b1, 1'b0, 16, inh_len, data_at, start_bit, bits, done_n, err_n, drops, ended_ok);
    n_checks++;
    if (inh_len !== INH) begin n_fail++; $display("FAIL ed_inhibit_len: got %0d required %0d", inh_len, INH); end
    n_checks++;
    if (data_at !== INH - 1) begin n_fail++; $display("FAIL ed_start_timing: got %0d required %0d", data_at, INH - 1); end
    n_checks++;
    if (start_bit !== 1'b0) begin n_fail++; $display("FAIL ed_start_bit: got %b required 0", start_bit); end
    n_checks++;
    if (bits !== exp) begin n_fail++; $display("FAIL ed_bits: got %b required %b", bits, exp); end
    n_checks++;
    if (!ended_ok || done_n !== 1 || err_n !== 0) begin
      n_fail++; $display("FAIL ed_outcome: got done=%0d error=%0d required done=1 error=0", done_n, err_n);
    end
    n_checks++;
    if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL ed_ready_after: got %b required 1", tx_ready); end
  endtask

  task automatic test_nack_01;
    int inh_len, data_at, done_n, err_n, drops;
    logic start_bit;
    logic [9:0] bits;
    bit ended_ok;
    run_frame(8'h01, 1'b0, 1'b0, 12, inh_len, data_at, start_bit, bits, done_n, err_n, drops, ended_ok);
    n_checks++;
    if (bits[8] !== 1'b0) begin n_fail++; $display("FAIL nack_parity: got %b required 0", bits[8]); end
    n_checks++;
    if (bits !== 10'b10_0000_0001) begin n_fail++; $display("FAIL nack_bits: got %b required 1000000001", bits); end
    n_checks++;
    if (!ended_ok || err_n !== 1 || done_n !== 0) begin
      n_fail++; $display("FAIL nack_outcome: got done=%0d error=%0d required done=0 error=1", done_n, err_n);
    end
  endtask

  task automatic test_ignore_while_busy;
    int inh_len, data_at, done_n, err_n, drops;
    logic start_bit;
    logic [9:0] bits;
    bit ended_ok;
    run_frame(8'hFF, 1'b1, 1'b1, 10, inh_len, data_at, start_bit, bits, done_n, err_n, drops, ended_ok);
    n_checks++;
    if (bits !== 10'b11_1111_1111) begin n_fail++; $display("FAIL busy_valid_bits: got %b required 1111111111", bits); end
    n_checks++;
    if (!ended_ok || done_n !== 1 || err_n !== 0) begin
      n_fail++; $display("FAIL busy_valid_outcome: got done=%0d error=%0d required done=1 error=0", done_n, err_n);
    end
    repeat (INH + 10) @(negedge clk);
    n_checks++;
    if (ps2_clk_oe !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL busy_valid_no_second_frame: got clk_oe=%b busy=%b required 0 0", ps2_clk_oe, busy);
    end
  endtask

  task automatic test_reset_mid_frame;
    int base_done, base_err, t;
    int inh_len, data_at, done_n, err_n, drops;
    logic start_bit;
    logic [9:0] bits, exp;
    bit ended_ok;
    logic [7:0] d;
    base_done = done_pulses;
    base_err  = err_pulses;
    @(negedge clk);
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    frame_active = 1'b1;
    t = 0;
    while (ps2_clk_oe && t < INH + 100) begin
      @(negedge clk);
      t++;
    end
    repeat (10) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      repeat (12) @(negedge clk);
      dev_clk = 1'b0;
      repeat (12) @(negedge clk);
      dev_clk = 1'b1;
    end
    rst = 1'b1;
    frame_active = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
      n_fail++; $display("FAIL midrst_pins: got %b required 00", {ps2_clk_oe, ps2_data_oe});
    end
    n_checks++;
    if (busy !== 1'b0 || tx_ready !== 1'b1) begin
      n_fail++; $display("FAIL midrst_state: got busy=%b ready=%b required 0 1", busy, tx_ready);
    end
    rst = 1'b0;
    repeat (30) @(negedge clk);
    n_checks++;
    if (done_pulses !== base_done || err_pulses !== base_err) begin
      n_fail++;
      $display("FAIL midrst_no_pulse: got done=%0d error=%0d required 0 0", done_pulses - base_done, err_pulses - base_err);
    end
    d = 8'($urandom_range(0, 255));
    exp = frame_bits(d);
    run_frame(d, 1'b1, 1'b0, 14, inh_len, data_at, start_bit, bits, done_n, err_n, drops, ended_ok);
    n_checks++;
    if (bits !== exp || !ended_ok || done_n !== 1) begin
      n_fail++; $display("FAIL midrst_next_frame: got bits=%b done=%0d required bits=%b done=1", bits, done_n, exp);
    end
  endtask

  task automatic test_held_low_clock;
    int inh_len, data_at, done_n, err_n, drops;
    logic start_bit;
    logic [9:0] bits, exp;
    bit ended_ok;
    dev_clk = 1'b0;
    repeat (100) @(negedge clk);
    dev_clk = 1'b1;
    repeat (10) @(negedge clk);
    exp = frame_bits(8'h3C);
    run_frame(8'h3C, 1'b1, 1'b0, 9, inh_len, data_at, start_bit, bits, done_n, err_n, drops, ended_ok);
    n_checks++;
    if (inh_len !== INH) begin n_fail++; $display("FAIL held_inhibit_len: got %0d required %0d", inh_len, INH); end
    n_checks++;
    if (drops !== 0) begin n_fail++; $display("FAIL held_busy: got %0d idle cycles in frame required 0", drops); end
    n_checks++;
    if (bits !== exp || done_n !== 1 || err_n !== 0) begin
      n_fail++; $display("FAIL held_frame: got bits=%b done=%0d err=%0d required bits=%b 1 0", bits, done_n, err_n, exp);
    end
  endtask

  task automatic test_random_frames;
    int inh_len, data_at, done_n, err_n, drops, half;
    logic start_bit;
    logic [9:0] bits, exp;
    bit ended_ok, ack;
    logic [7:0] d;
    for (int i = 0; i < 6; i++) begin
      d    = 8'($urandom_range(0, 255));
      ack  = 1'($urandom_range(0, 1));
      half = $urandom_range(8, 20);
      exp  = frame_bits(d);
      run_frame(d, ack, 1'b0, half, inh_len, data_at, start_bit, bits, done_n, err_n, drops, ended_ok);
      n_checks++;
      if (bits !== exp) begin n_fail++; $display("FAIL rnd%0d_bits: got %b required %b", i, bits, exp); end
      n_checks++;
      if (inh_len !== INH || data_at !== INH - 1 || start_bit !== 1'b0) begin
        n_fail++;
        $display("FAIL rnd%0d_inhibit: got len=%0d start_at=%0d start=%b required %0d %0d 0", i, inh_len, data_at, start_bit, INH, INH - 1);
      end
      n_checks++;
      if (!ended_ok || done_n !== (ack ? 1 : 0) || err_n !== (ack ? 0 : 1)) begin
        n_fail++; $display("FAIL rnd%0d_outcome: got done=%0d error=%0d for ack=%b", i, done_n, err_n, ack);
      end
      n_checks++;
      if (drops !== 0 || tx_ready !== 1'b1) begin
        n_fail++; $display("FAIL rnd%0d_busy_ready: got drops=%0d ready=%b required 0 1", i, drops, tx_ready);
      end
    end
  endtask

`ifdef PS2_HOST_TX_TIMEOUT_EN
  task automatic test_timeout;
    int t;
    @(negedge clk);
    tx_data  = 8'($urandom_range(0, 255));
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    frame_active = 1'b1;
    t = 0;
    while (ps2_clk_oe && t < INH + 100) begin
      @(negedge clk);
      t++;
    end
    t = 0;
    while (!tx_error && t < 3 * TMO) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (t !== TMO) begin n_fail++; $display("FAIL timeout_latency: got %0d required %0d", t, TMO); end
    n_checks++;
    if ({ps2_clk_oe, ps2_data_oe} !== 2'b00 || tx_ready !== 1'b1) begin
      n_fail++; $display("FAIL timeout_release: got oe=%b ready=%b required 00 1", {ps2_clk_oe, ps2_data_oe}, tx_ready);
    end
    repeat (5) @(negedge clk);
    frame_active = 1'b0;
  endtask
`endif

  task automatic test_invariants;
    n_checks++;
    if (mon_viol !== 0) begin
      n_fail++; $display("FAIL invariants: got %0d violating cycles required 0", mon_viol);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_ack_ed();
    test_nack_01();
    test_ignore_while_busy();
    test_reset_mid_frame();
    test_held_low_clock();
    test_random_frames();
`ifdef PS2_HOST_TX_TIMEOUT_EN
    test_timeout();
`endif
    test_invariants();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
